fetch_sequencer: RTL and testbench

- Controls the instruction fetch path and drives the instruction-memory request handshake.
- Owns the fetch PC and arbitrates between fetch-control sources in priority order: halt, absolute branch, relative branch, stall, sequential increment.
- Delivers one fetched instruction per accepted memory response to decode.
- Adds bounded-wait timeout detection and a halt/resume facility for debug.

---
 rtl/fetch_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, drives the imem handshake and
// delivers one instruction per accepted response. Optional macro FETCH_ALIGN_CHECK_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_abs_valid,
    input  logic [31:0] br_abs_addr,
    input  logic        br_rel_valid,
    input  logic [31:0] br_rel_offset,
    input  logic        halt_req,
    input  logic        resume,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        fault,
    output logic [2:0]  state
);

    // state | meaning
    // IDLE  | out of reset, fetch starts next edge
    // FETCH | request at fetch_pc held until ack
    // HOLD  | downstream stalled, no request
    // HALT  | debug halt, waits for resume
    // FAULT | timeout or misaligned redirect, left only by reset
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [31:0] STEP      = 32'(PC_STEP);

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        iv_q, iv_d;
    logic        fault_q, fault_d;
    logic [7:0]  wait_q, wait_d;

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        misalign;
    logic        redirect_ok;
    logic        align_fault;
    logic        timeout;

    assign redirect   = br_abs_valid | br_rel_valid;
    assign target_raw = br_abs_valid ? br_abs_addr : (pc_q + br_rel_offset);

`ifdef FETCH_ALIGN_CHECK_EN
    assign target   = target_raw;
    assign misalign = (target_raw[1:0] != 2'b00);
`else
    assign target   = target_raw & ~32'h3;
    assign misalign = 1'b0;
`endif

    assign redirect_ok = redirect &&
                         (state_q == ST_FETCH || state_q == ST_HOLD || state_q == ST_HALT);
    assign align_fault = redirect_ok && misalign;
    // Fires on the MAX_WAIT-th consecutive unanswered request cycle.
    assign timeout     = (state_q == ST_FETCH) && !imem_ack && (wait_q == WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        iv_d       = 1'b0;
        fault_d    = fault_q;
        wait_d     = 8'd0;

        case (state_q)
            ST_IDLE: begin
                state_d = halt_req ? ST_HALT : ST_FETCH;
            end
            ST_FETCH: begin
                if (timeout || align_fault) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    if (redirect) begin
                        fetch_pc_d = target;
                    end else if (imem_ack) begin
                        instr_d    = imem_rdata;
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + STEP;
                        iv_d       = 1'b1;
                    end
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (stall) begin
                        state_d = ST_HOLD;
                    end else if (!imem_ack && !redirect) begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (align_fault) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    if (redirect) fetch_pc_d = target;
                    if (halt_req)    state_d = ST_HALT;
                    else if (!stall) state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (align_fault) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    if (redirect) fetch_pc_d = target;
                    if (resume && !halt_req) state_d = ST_FETCH;
                end
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            iv_q       <= 1'b0;
            fault_q    <= 1'b0;
            wait_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            iv_q       <= iv_d;
            fault_q    <= fault_d;
            wait_q     <= wait_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = iv_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign fault       = fault_q;
    assign state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer; memory returns addr ^ 32'hA5A5_A5A5.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_abs_valid;
    logic [31:0] br_abs_addr;
    logic        br_rel_valid;
    logic [31:0] br_rel_offset;
    logic        halt_req;
    logic        resume;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
    logic [2:0]  state;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .br_abs_valid (br_abs_valid),
        .br_abs_addr  (br_abs_addr),
        .br_rel_valid (br_rel_valid),
        .br_rel_offset(br_rel_offset),
        .halt_req     (halt_req),
        .resume       (resume),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc           (pc),
        .fault        (fault),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_A5A5;

    // ctl bits: [3] stall, [2] halt_req, [1] resume, [0] imem_ack
    localparam logic [3:0] N = 4'b0000;
    localparam logic [3:0] K = 4'b0001;
    localparam logic [3:0] R = 4'b0010;
    localparam logic [3:0] H = 4'b0100;
    localparam logic [3:0] S = 4'b1000;

    typedef struct {
        logic [3:0]  ctl;
        logic        av;
        logic [31:0] aa;
        logic        rv;
        logic [31:0] ro;
        logic [2:0]  e_state;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_fault;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] c, input logic av, input logic [31:0] aa,
                                input logic rv, input logic [31:0] ro,
                                input logic [2:0] es, input logic er, input logic [31:0] ea,
                                input logic ei, input logic [31:0] einstr,
                                input logic [31:0] epc, input logic ef);
        vec_t v;
        v.ctl = c; v.av = av; v.aa = aa; v.rv = rv; v.ro = ro;
        v.e_state = es; v.e_req = er; v.e_addr = ea; v.e_iv = ei;
        v.e_instr = einstr; v.e_pc = epc; v.e_fault = ef;
        tbl.push_back(v);
    endfunction

    task automatic drive(input logic [3:0] c, input logic av, input logic [31:0] aa,
                         input logic rv, input logic [31:0] ro);
        stall         = c[3];
        halt_req      = c[2];
        resume        = c[1];
        imem_ack      = c[0];
        br_abs_valid  = av;
        br_abs_addr   = aa;
        br_rel_valid  = rv;
        br_rel_offset = ro;
    endtask

    task automatic check(input string name, input logic [2:0] es, input logic er,
                         input logic [31:0] ea, input logic ei, input logic [31:0] einstr,
                         input logic [31:0] epc, input logic ef);
        n_vec++;
        if ({state, imem_req, imem_addr, instr_valid, instr, pc, fault} !==
            {es, er, ea, ei, einstr, epc, ef}) begin
            n_miss++;
            $display("FAIL %s: got state=%0d req=%b addr=%h iv=%b instr=%h pc=%h fault=%b, want state=%0d req=%b addr=%h iv=%b instr=%h pc=%h fault=%b",
                     name, state, imem_req, imem_addr, instr_valid, instr, pc, fault,
                     es, er, ea, ei, einstr, epc, ef);
        end
    endtask

    task automatic tick_check(input string name, input logic [2:0] es, input logic er,
                              input logic [31:0] ea, input logic ei, input logic [31:0] einstr,
                              input logic [31:0] epc, input logic ef);
        @(posedge clk);
        #1;
        check(name, es, er, ea, ei, einstr, epc, ef);
    endtask

    task automatic release_reset();
        drive(N, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(N, 1'b0, 32'h0, 1'b0, 32'h0);

        // streaming fetch with ack every cycle
        add(N, 0, 0, 0, 0,            1, 1, 32'h00,  0, 32'h0,         32'h00, 0);
        add(K, 0, 0, 0, 0,            1, 1, 32'h04,  1, 32'hA5A5_A5A5, 32'h00, 0);
        add(K, 0, 0, 0, 0,            1, 1, 32'h08,  1, 32'hA5A5_A5A1, 32'h04, 0);
        add(K, 0, 0, 0, 0,            1, 1, 32'h0C,  1, 32'hA5A5_A5AD, 32'h08, 0);
        add(K, 0, 0, 0, 0,            1, 1, 32'h10,  1, 32'hA5A5_A5A9, 32'h0C, 0);
        add(K, 0, 0, 0, 0,            1, 1, 32'h14,  1, 32'hA5A5_A5B5, 32'h10, 0);
        // abs wins over rel; same-cycle ack dropped
        add(K, 1, 32'h100, 1, 32'hFFFF_FFF0, 1, 1, 32'h100, 0, 32'hA5A5_A5B5, 32'h10, 0);
        // rel only: 0x10 + (-16) wraps to 0
        add(K, 0, 0, 1, 32'hFFFF_FFF0,  1, 1, 32'h00,  0, 32'hA5A5_A5B5, 32'h10, 0);
        add(K, 0, 0, 0, 0,            1, 1, 32'h04,  1, 32'hA5A5_A5A5, 32'h00, 0);
        // stall with ack in entry cycle, held 3 cycles
        add(S | K, 0, 0, 0, 0,        2, 0, 32'h08,  1, 32'hA5A5_A5A1, 32'h04, 0);
        add(S, 0, 0, 0, 0,            2, 0, 32'h08,  0, 32'hA5A5_A5A1, 32'h04, 0);
        add(S, 0, 0, 0, 0,            2, 0, 32'h08,  0, 32'hA5A5_A5A1, 32'h04, 0);
        add(N, 0, 0, 0, 0,            1, 1, 32'h08,  0, 32'hA5A5_A5A1, 32'h04, 0);
        add(K, 0, 0, 0, 0,            1, 1, 32'h0C,  1, 32'hA5A5_A5AD, 32'h08, 0);
        // halt + redirect + ack: redirect taken, ack dropped
        add(H | K, 1, 32'h40, 0, 0,   3, 0, 32'h40,  0, 32'hA5A5_A5AD, 32'h08, 0);
        add(N, 0, 0, 0, 0,            3, 0, 32'h40,  0, 32'hA5A5_A5AD, 32'h08, 0);
        add(H | R, 0, 0, 0, 0,        3, 0, 32'h40,  0, 32'hA5A5_A5AD, 32'h08, 0);
        add(R, 0, 0, 0, 0,            1, 1, 32'h40,  0, 32'hA5A5_A5AD, 32'h08, 0);
        add(K, 0, 0, 0, 0,            1, 1, 32'h44,  1, 32'hA5A5_A5E5, 32'h40, 0);
        // no ack: 14 waiting cycles, fault on the 15th
        for (int i = 0; i < 14; i++)
            add(N, 0, 0, 0, 0,        1, 1, 32'h44,  0, 32'hA5A5_A5E5, 32'h40, 0);
        add(N, 0, 0, 0, 0,            4, 0, 32'h44,  0, 32'hA5A5_A5E5, 32'h40, 1);
        add(R | K, 1, 32'h0, 1, 32'h4, 4, 0, 32'h44, 0, 32'hA5A5_A5E5, 32'h40, 1);
        add(H | S | K, 0, 0, 0, 0,    4, 0, 32'h44,  0, 32'hA5A5_A5E5, 32'h40, 1);

        #12;
        check("reset_values", 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        release_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].ctl, tbl[i].av, tbl[i].aa, tbl[i].rv, tbl[i].ro);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_req, tbl[i].e_addr,
                  tbl[i].e_iv, tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_fault);
        end

        // async reset clears a sticky fault without a clock edge
        reset = 1'b0;
        #1;
        check("fault_cleared_by_reset", 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        release_reset();
        tick_check("refetch", 3'd1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
        end
        #1;
        check("wait7_req_held", 3'd1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

        // reset mid-wait together with a late ack
        imem_ack = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_midwait", 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick_check("late_ack_ignored", 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        release_reset();
        tick_check("restart", 3'd1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
        end
        tick_check("wait_counter_restarted", 3'd1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick_check("timeout_again", 3'd4, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);

        // misaligned absolute target
        reset = 1'b0;
        #1;
        release_reset();
        tick_check("align_start", 3'd1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(K, 1'b0, 32'h0, 1'b0, 32'h0);
        tick_check("align_first", 3'd1, 1'b1, 32'h4, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0);
        drive(K, 1'b1, 32'h42, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        tick_check("misaligned_abs", 3'd4, 1'b0, 32'h4, 1'b0, 32'hA5A5_A5A5, 32'h0, 1'b1);
        drive(K, 1'b0, 32'h0, 1'b0, 32'h0);
        tick_check("misaligned_stays", 3'd4, 1'b0, 32'h4, 1'b0, 32'hA5A5_A5A5, 32'h0, 1'b1);
`else
        tick_check("misaligned_abs", 3'd1, 1'b1, 32'h40, 1'b0, 32'hA5A5_A5A5, 32'h0, 1'b0);
        drive(K, 1'b0, 32'h0, 1'b0, 32'h0);
        tick_check("after_forced_align", 3'd1, 1'b1, 32'h44, 1'b1, 32'hA5A5_A5E5, 32'h40, 1'b0);
`endif
        drive(N, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
